// File: rtl/cache_refill_unit_if.sv
// +--------------------------------------------------------------------------+
// | Interfaces : cache_refill_req_if, cache_refill_mem_if                     |
// | Purpose    : Bundles for cache_refill_unit.                               |
// |              cache_refill_req_if - cache-side request/response channel    |
// |                master = cache (or arbiter), slave = refill unit           |
// |                req_valid/req_ready handshake, req_tag/index/offset,       |
// |                req_cached/req_wr/req_wdata/req_wstrb,                     |
// |                resp_valid pulse, resp_line (refilled line), resp_word     |
// |              cache_refill_mem_if - SRAM-like memory bus                   |
// |                master = refill unit, slave = memory bridge                |
// |                mem_req/mem_wr/mem_addr/mem_wdata/mem_wstrb,               |
// |                mem_addr_ok, mem_data_ok, mem_rdata                        |
// | Revision   : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
`default_nettype none

interface cache_refill_req_if #(
    parameter int TAG_W   = 20,
    parameter int INDEX_W = 8,
    parameter int OFF_W   = 4
);
    localparam int LINE_W = 8 * (2 ** OFF_W);

    logic               req_valid;
    logic               req_ready;
    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] req_index;
    logic [OFF_W-1:0]   req_offset;
    logic               req_cached;
    logic               req_wr;
    logic [31:0]        req_wdata;
    logic [3:0]         req_wstrb;
    logic               resp_valid;
    logic [LINE_W-1:0]  resp_line;
    logic [31:0]        resp_word;

    modport master (
        output req_valid, req_tag, req_index, req_offset, req_cached,
               req_wr, req_wdata, req_wstrb,
        input  req_ready, resp_valid, resp_line, resp_word
    );

    modport slave (
        input  req_valid, req_tag, req_index, req_offset, req_cached,
               req_wr, req_wdata, req_wstrb,
        output req_ready, resp_valid, resp_line, resp_word
    );
endinterface

interface cache_refill_mem_if;
    logic        mem_req;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_wr, mem_addr, mem_wdata, mem_wstrb,
        input  mem_addr_ok, mem_data_ok, mem_rdata
    );

    modport slave (
        input  mem_req, mem_wr, mem_addr, mem_wdata, mem_wstrb,
        output mem_addr_ok, mem_data_ok, mem_rdata
    );
endinterface

`default_nettype wire

// File: rtl/cache_refill_unit.sv
// +--------------------------------------------------------------------------+
// | Module   : cache_refill_unit                                             |
// | Purpose  : Memory-side refill engine. Takes a cache miss/uncached request |
// |            split into tag/index/offset, rebuilds the physical address    |
// |            and runs it over an SRAM-like req/addr_ok/data_ok bus.        |
// |            Cached requests refill a whole line one word per beat;        |
// |            uncached requests perform a single word read or write.        |
// | Ports    : clk      - clock, rising edge                                 |
// |            rst      - asynchronous active-high reset                     |
// |            req_if   - cache-side channel (slave modport)                 |
// |            mem_if   - memory bus (master modport)                        |
// | Options  : `define CRITICAL_WORD_FIRST_EN to start a refill at the word   |
// |            addressed by req_offset and wrap; default order is 0,1,2,3.   |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module cache_refill_unit #(
    parameter int TAG_W   = 20,
    parameter int INDEX_W = 8,
    parameter int OFF_W   = 4
) (
    input wire              clk,
    input wire              rst,
    cache_refill_req_if.slave  req_if,
    cache_refill_mem_if.master mem_if
);
    localparam int WORDS  = 2 ** (OFF_W - 2);
    localparam int BEAT_W = OFF_W - 2;
    localparam int LINE_W = 32 * WORDS;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_RESP = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic [TAG_W-1:0]   tag_q;
    logic [INDEX_W-1:0] index_q;
    logic [OFF_W-1:0]   offset_q;
    logic               cached_q;
    logic               wr_q;
    logic [31:0]        wdata_q;
    logic [3:0]         wstrb_q;
    logic [BEAT_W-1:0]  beat_q;
    logic [LINE_W-1:0]  line_q;
    logic [31:0]        word_q;

    logic               accept;
    logic [BEAT_W-1:0]  word_sel;
    logic [31:0]        beat_addr;

    assign accept = (state_q == S_IDLE) && req_if.req_valid;

    // beat_q counts completed beats; word_sel maps it to the line slot.
`ifdef CRITICAL_WORD_FIRST_EN
    // Start at the requested word and wrap naturally in BEAT_W bits.
    assign word_sel = offset_q[OFF_W-1:2] + beat_q;
`else
    assign word_sel = beat_q;
`endif

    assign beat_addr = cached_q ? {tag_q, index_q, word_sel, 2'b00}
                                : {tag_q, index_q, offset_q};

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (req_if.req_valid)     state_d = S_ADDR;
            S_ADDR: if (mem_if.mem_addr_ok)   state_d = S_DATA;
            S_DATA: begin
                if (mem_if.mem_data_ok) begin
                    // Only cached refills loop back for another beat.
                    if (cached_q && !(&beat_q)) state_d = S_ADDR;
                    else                        state_d = S_RESP;
                end
            end
            S_RESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------ outputs
    // Bus outputs are forced to zero outside ADDR so the bus is quiet
    // whenever no address phase is in flight (including straight out of reset).
    always_comb begin
        req_if.req_ready  = (state_q == S_IDLE);
        req_if.resp_valid = (state_q == S_RESP);
        req_if.resp_line  = line_q;
        req_if.resp_word  = word_q;
        mem_if.mem_req    = 1'b0;
        mem_if.mem_wr     = 1'b0;
        mem_if.mem_addr   = 32'h0;
        mem_if.mem_wdata  = 32'h0;
        mem_if.mem_wstrb  = 4'h0;
        if (state_q == S_ADDR) begin
            mem_if.mem_req  = 1'b1;
            mem_if.mem_addr = beat_addr;
            if (!cached_q && wr_q) begin
                mem_if.mem_wr    = 1'b1;
                mem_if.mem_wdata = wdata_q;
                mem_if.mem_wstrb = wstrb_q;
            end
        end
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_q    <= '0;
            index_q  <= '0;
            offset_q <= '0;
            cached_q <= 1'b0;
            wr_q     <= 1'b0;
            wdata_q  <= 32'h0;
            wstrb_q  <= 4'h0;
            beat_q   <= '0;
            line_q   <= '0;
            word_q   <= 32'h0;
        end else begin
            if (accept) begin
                tag_q    <= req_if.req_tag;
                index_q  <= req_if.req_index;
                offset_q <= req_if.req_offset;
                cached_q <= req_if.req_cached;
                wr_q     <= req_if.req_wr;
                wdata_q  <= req_if.req_wdata;
                wstrb_q  <= req_if.req_wstrb;
                beat_q   <= '0;
            end
            // data_ok is only honoured in DATA, so a pulse that coincides
            // with addr_ok (still in ADDR) never completes a beat.
            if ((state_q == S_DATA) && mem_if.mem_data_ok) begin
                if (cached_q) begin
                    line_q[{word_sel, 5'd0} +: 32] <= mem_if.mem_rdata;
                    beat_q <= beat_q + 1'b1;
                end else if (!wr_q) begin
                    word_q <= mem_if.mem_rdata;
                end
            end
        end
    end

endmodule

`default_nettype wire
